// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and the MEM stage
// (MEM has priority), aborts stuck accesses after TIMEOUT cycles, drives the stall vector.
module mem_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_sel,
   output logic [31:0] mem_rdata,
   output logic        mem_ready,
   output logic        bus_err,
   output logic        ram_ce,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   output logic [3:0]  ram_sel,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ack,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   output logic [5:0]  stall
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_BUSY_IF  = 2'd1;
   localparam logic [1:0] S_BUSY_MEM = 2'd2;
   localparam logic [1:0] S_DONE     = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ram_ce_q, ram_ce_d;
   logic             ram_we_q, ram_we_d;
   logic [31:0]      ram_addr_q, ram_addr_d;
   logic [31:0]      ram_wdata_q, ram_wdata_d;
   logic [3:0]       ram_sel_q, ram_sel_d;
   logic [31:0]      if_rdata_q, if_rdata_d;
   logic [31:0]      mem_rdata_q, mem_rdata_d;
   logic             if_ready_q, if_ready_d;
   logic             mem_ready_q, mem_ready_d;
   logic             bus_err_q, bus_err_d;

   // Grant, wait/timeout and completion sequencing
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ram_ce_d    = ram_ce_q;
      ram_we_d    = ram_we_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_sel_d   = ram_sel_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;
      if_ready_d  = 1'b0;
      mem_ready_d = 1'b0;
      bus_err_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_req) begin
               ram_ce_d    = 1'b1;
               ram_we_d    = mem_we;
               ram_addr_d  = mem_addr;
               ram_wdata_d = mem_wdata;
               ram_sel_d   = mem_sel;
               cnt_d       = '0;
               state_d     = S_BUSY_MEM;
            end else if (if_req) begin
               ram_ce_d    = 1'b1;
               ram_we_d    = 1'b0;
               ram_addr_d  = if_addr;
               ram_wdata_d = 32'd0;
               ram_sel_d   = 4'hF;
               cnt_d       = '0;
               state_d     = S_BUSY_IF;
            end
         end
         S_BUSY_IF, S_BUSY_MEM: begin
            // An ack on the last allowed cycle still completes normally
            if (ram_ack || cnt_q == CNT_LAST) begin
               ram_ce_d  = 1'b0;
               ram_we_d  = 1'b0;
               bus_err_d = ~ram_ack;
               state_d   = S_DONE;
               if (state_q == S_BUSY_IF) begin
                  if_rdata_d = ram_ack ? ram_rdata : 32'd0;
                  if_ready_d = 1'b1;
               end else begin
                  mem_rdata_d = ram_ack ? ram_rdata : 32'd0;
                  mem_ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         ram_ce_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= 32'd0;
         ram_wdata_q <= 32'd0;
         ram_sel_q   <= 4'd0;
         if_rdata_q  <= 32'd0;
         mem_rdata_q <= 32'd0;
         if_ready_q  <= 1'b0;
         mem_ready_q <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ram_ce_q    <= ram_ce_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_sel_q   <= ram_sel_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
         if_ready_q  <= if_ready_d;
         mem_ready_q <= mem_ready_d;
         bus_err_q   <= bus_err_d;
      end
   end

   // Stall vector: deepest requesting stage wins
   always_comb begin
      stall = 6'b000000;
      if (!rst) begin
         if (mem_req && !mem_ready_q)     stall = 6'b011111;
         else if (stallreq_ex)            stall = 6'b001111;
         else if (stallreq_id)            stall = 6'b000111;
         else if (if_req && !if_ready_q)  stall = 6'b000011;
      end
   end

   assign ram_ce    = ram_ce_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign ram_sel   = ram_sel_q;
   assign if_rdata  = if_rdata_q;
   assign if_ready  = if_ready_q;
   assign mem_rdata = mem_rdata_q;
   assign mem_ready = mem_ready_q;
   assign bus_err   = bus_err_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter and pipeline stall controller for the 5-stage core. Shares one external RAM port between instruction fetch (IF) and the data-memory stage (MEM) with fixed MEM priority and a bounded-wait timeout. Drives the 6-bit stall vector consumed by the PC and pipeline registers, merging memory-wait stalls with stall requests from ID and EX.

## Interface
- TIMEOUT, 16: maximum cycles a granted access waits for `ram_ack` before abort; legal range 2..255.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  IF read request; held with `if_addr` stable until `if_ready`.
- if_addr  in  32  fetch address.
- if_rdata  out  32  fetched word; valid while `if_ready`=1.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_req  in  1  MEM access request; held with its fields stable until `mem_ready`.
- mem_we  in  1  1=write, 0=read.
- mem_addr  in  32  data address.
- mem_wdata  in  32  write data.
- mem_sel  in  4  byte enables.
- mem_rdata  out  32  read word; valid while `mem_ready`=1.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- bus_err  out  1  one-cycle pulse, coincident with ready, on timeout abort.
- ram_ce, ram_we  out  1 each  RAM strobe and write enable.
- ram_addr, ram_wdata  out  32 each  RAM address and write data.
- ram_sel  out  4  RAM byte enables.
- ram_rdata  in  32  RAM read data; sampled when `ram_ack`=1.
- ram_ack  in  1  RAM completion; meaningful only while `ram_ce`=1.
- stallreq_id, stallreq_ex  in  1 each  stall requests from ID and EX.
- stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1=hold.

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_MEM, DONE.
- IDLE: `mem_req` -> latch MEM fields into `ram_*`, `ram_ce`=1, `ram_we`=`mem_we`, -> BUSY_MEM. Else `if_req` -> `ram_addr`=`if_addr`, `ram_we`=0, `ram_sel`=4'hF, `ram_wdata`=0, -> BUSY_IF. If both requests are high, MEM wins; IF waits.
- BUSY_x: `ram_*` held constant; wait counter increments each cycle from 0.
- `ram_ack`=1 -> `ram_ce`=0, `ram_we`=0; owner's rdata register <= `ram_rdata` (MEM writes also capture, value don't-care); owner's ready=1; -> DONE.
- Counter reaches TIMEOUT-1 with no ack -> `ram_ce`=0, owner rdata <= 0, owner ready=1, `bus_err`=1 -> DONE. Ack in that same cycle takes precedence (normal completion, no error).
- DONE: ready/bus_err high this cycle only; no new grant is made; -> IDLE. The requester drops or re-presents its request after DONE.
- `ram_ack` in IDLE or DONE is ignored.
- Counter width: ceil(log2(TIMEOUT)); cleared on every grant.
- Stall, combinational, highest-priority case wins:
  - `mem_req` & !`mem_ready` -> 6'b011111.
  - else `stallreq_ex` -> 6'b001111.
  - else `stallreq_id` -> 6'b000111.
  - else `if_req` & !`if_ready` -> 6'b000011.
  - else 6'b000000.
  - `rst`=1 forces 6'b000000.

## Timing
- Reset values (registered outputs, next edge with `rst`=1): state IDLE, `ram_ce` 0, `ram_we` 0, `ram_addr` 0, `ram_wdata` 0, `ram_sel` 0, `if_rdata` 0, `mem_rdata` 0, `if_ready` 0, `mem_ready` 0, `bus_err` 0, counter 0.
- Request high in cycle c while IDLE -> `ram_ce` high from c+1.
- Ack sampled in cycle a -> ready high in cycle a+1, `ram_ce` low in a+1.
- Minimum request-to-ready latency is 2 cycles (ack in c+1); the next grant occurs no earlier than c+3.
- Timeout: ready/bus_err high in cycle c+1+TIMEOUT.
- Reset during BUSY: `ram_ce` drops at that edge, no ready pulse, and a later stray ack is ignored.
- All outputs except `stall` are registered.

## Test plan
- Reset: assert `rst` 2 cycles -> all registered outputs 0, `stall`=0; stray `ram_ack`=1 causes no ready.
- IF read: `if_addr`=0x00000040, ack after 2 wait cycles with `ram_rdata`=0x3C010001 -> `ram_ce` 3 cycles, `if_ready` one cycle with `if_rdata`=0x3C010001; `stall`=6'b000011 until ready.
- Contention: `if_req` and `mem_req` (read 0x100) raised in the same cycle -> MEM granted first, `stall`=6'b011111; IF is granted only after MEM DONE, and `ram_addr` then shows the IF address.
- Byte write: `mem_we`=1, `mem_sel`=4'b0010, `mem_wdata`=0x0000AB00 -> `ram_we`=1, `ram_sel`=0010, fields held until ack, then `mem_ready` pulse.
- Timeout: TIMEOUT=4, no ack -> `ram_ce` high exactly 4 cycles, then `mem_ready`=1, `bus_err`=1, `mem_rdata`=0; ack at counter 3 -> no `bus_err`.
- Stall priority and reset mid-op: `stallreq_ex`=1 with IF pending -> 6'b001111; `stallreq_id` alone -> 6'b000111; `rst` in BUSY_IF -> `ram_ce`=0 at next edge, no `if_ready`.
